dsp_mac_sequencer: RTL and testbench
====================================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 Parameter: LEN_W, 8, width of the operand-count field (1..12).
REQ-002 Port: CLK  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port: RST_N  in  1  asynchronous active-low reset.
REQ-004 Port: start  in  1  command strobe, sampled in IDLE only.
REQ-005 Port: len  in  LEN_W  number of operand pairs, sampled with start.
REQ-006 Port: op_valid / op_ready  in / out  1 / 1  operand-stream handshake.
REQ-007 Port: op_a, op_b  in  18 each  unsigned operand pair.
REQ-008 Port: dsp_A, dsp_B  out  18 each  slice A and B inputs.
REQ-009 Port: dsp_OPMODE  out  8  slice OPMODE.
REQ-010 Port: dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP, dsp_CEOPMODE, dsp_RSTP  out  1 each  slice clock enables and P sync reset.
REQ-011 Port: dsp_P  in  48  slice P output.
REQ-012 Port: res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-013 Port: res_data  out  48  dot-product result.
REQ-014 Port: busy  out  1  high whenever state != IDLE.

Function
REQ-015 Block SHALL target a slice built with A0REG=B0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=1, B_INPUT=DIRECT, CARRYINSEL=OPMODE5.
REQ-016 dsp_OPMODE SHALL be constant 8'h09 (X=M, Z=P, add, no pre-add, carry 0); dsp_CEOPMODE SHALL be 1 whenever RST_N is high.
REQ-017 FSM states SHALL be IDLE, CLEAR, STREAM, DRAIN, RESULT.
REQ-018 IDLE: start with len!=0 -> CLEAR, remaining count <= len; start with len==0 -> RESULT with res_data <= 0; start is ignored in every other state.
REQ-019 CLEAR: dsp_RSTP=1 for exactly one cycle, then -> STREAM; dsp_RSTP SHALL be 0 in all other states.
REQ-020 STREAM: op_ready=1; accept = op_valid & op_ready; dsp_A/dsp_B = op_a/op_b combinationally; dsp_CEA = dsp_CEB = accept.
REQ-021 Accept at cycle t SHALL produce dsp_CEM=1 at t+1 and dsp_CEP=1 at t+2 via a 2-stage valid shift register; otherwise CEM and CEP are 0, so bubbles never re-accumulate a stale M.
REQ-022 Each accept SHALL decrement the remaining count; the accept taking it to 0 -> DRAIN; op_ready=0 outside STREAM.
REQ-023 DRAIN SHALL last exactly 3 cycles; at the end of the 3rd, res_data <= dsp_P, -> RESULT.
REQ-024 Back-to-back accepts t..t+len-1 SHALL give res_valid first high at cycle t+len+3.
REQ-025 RESULT: res_valid=1 and res_data stable until res_ready=1, then -> IDLE on the same edge.
REQ-026 Arithmetic SHALL be unsigned; LEN_W<=12 guarantees no 48-bit overflow; slice CARRYOUT is ignored.

Reset
REQ-027 RST_N low SHALL force IDLE immediately, including mid-STREAM or DRAIN.
REQ-028 Reset SHALL clear the valid pipe and the count, with all outputs 0: op_ready, res_valid, res_data, busy, dsp_A, dsp_B, dsp_OPMODE, all CE outputs and dsp_RSTP.
REQ-029 After reset the next command SHALL pass through CLEAR, so stale P contents never reach res_data.

Configuration
REQ-030 Macro MAC_SEQ_ABORT_EN: when defined, adds input abort (1 bit); abort=1 in CLEAR, STREAM or DRAIN SHALL -> IDLE next edge, clear the valid pipe, assert no CE, and produce no res_valid.
REQ-031 Without MAC_SEQ_ABORT_EN the abort port SHALL not exist and commands always run to RESULT.

Verification
REQ-032 len=3, pairs (2,3),(4,5),(6,7) back-to-back from cycle t -> res_valid at t+6, res_data=68.
REQ-033 Same pairs with op_valid low for 2 cycles between pairs -> res_data=68; CEP high exactly 3 cycles total.
REQ-034 len=0 start -> res_valid the next cycle, res_data=0, no CE or dsp_RSTP asserted.
REQ-035 len=255, all operands 18'h3FFFF -> res_data=17523332874495; res_ready held low 10 cycles -> res_valid and res_data stable throughout.
REQ-036 RST_N low mid-STREAM (after 2 of 5 pairs), then new len=1 (3,3) command -> res_data=9.
REQ-037 With MAC_SEQ_ABORT_EN, abort in DRAIN -> IDLE next cycle, busy=0, res_valid never asserted.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer for a pipelined DSP slice (AREG/BREG/MREG/PREG=1).
// Optional abort input enabled by defining MAC_SEQ_ABORT_EN.
module dsp_mac_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
`ifdef MAC_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CEA,
  output logic             dsp_CEB,
  output logic             dsp_CEM,
  output logic             dsp_CEP,
  output logic             dsp_CEOPMODE,
  output logic             dsp_RSTP,
  input  logic [47:0]      dsp_P,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_RESULT
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [1:0]       vpipe_q;
  logic [1:0]       drain_q;
  logic [47:0]      res_q;

  logic abort_w;
  logic active;
  logic kill;
  logic accept;

`ifdef MAC_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign active = (state_q == S_CLEAR) ||
                  (state_q == S_STREAM) ||
                  (state_q == S_DRAIN);
  assign kill   = abort_w & active;

  assign op_ready = (state_q == S_STREAM) & ~kill;
  assign accept   = op_valid & op_ready;

  assign dsp_A = (state_q == S_STREAM) ? op_a : 18'd0;
  assign dsp_B = (state_q == S_STREAM) ? op_b : 18'd0;

  // X=M, Z=P, add; only held at zero while reset is asserted
  assign dsp_OPMODE   = RST_N ? 8'h09 : 8'h00;
  assign dsp_CEOPMODE = RST_N;

  assign dsp_CEA  = accept;
  assign dsp_CEB  = accept;
  assign dsp_CEM  = vpipe_q[0] & ~kill;
  assign dsp_CEP  = vpipe_q[1] & ~kill;
  assign dsp_RSTP = (state_q == S_CLEAR);

  assign res_valid = (state_q == S_RESULT);
  assign res_data  = res_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vpipe_q <= '0;
      drain_q <= '0;
      res_q   <= '0;
    end else begin
      vpipe_q <= {vpipe_q[0], accept};
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state_q <= S_CLEAR;
              cnt_q   <= len;
            end else begin
              state_q <= S_RESULT;
              res_q   <= '0;
            end
          end
        end
        S_CLEAR: state_q <= S_STREAM;
        S_STREAM: begin
          if (accept) begin
            cnt_q <= cnt_q - ONE;
            if (cnt_q == ONE) begin
              state_q <= S_DRAIN;
              drain_q <= '0;
            end
          end
        end
        S_DRAIN: begin
          drain_q <= drain_q + 2'd1;
          // P carries the last product during the third drain cycle
          if (drain_q == 2'd2) begin
            res_q   <= dsp_P;
            state_q <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (kill) begin
        state_q <= S_IDLE;
        vpipe_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP slice model.
// Abort scenario is exercised when MAC_SEQ_ABORT_EN is defined.
module tb_dsp_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [17:0] op_a = 18'd0;
  logic [17:0] op_b = 18'd0;
  logic [17:0] dsp_A, dsp_B;
  logic [7:0]  dsp_OPMODE;
  logic        dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP;
  logic        dsp_CEOPMODE, dsp_RSTP;
  logic [47:0] dsp_P;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [47:0] res_data;
  logic        busy;
`ifdef MAC_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  dsp_mac_sequencer #(.LEN_W(8)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .start(start),
    .len(len),
`ifdef MAC_SEQ_ABORT_EN
    .abort(abort),
`endif
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_a(op_a),
    .op_b(op_b),
    .dsp_A(dsp_A),
    .dsp_B(dsp_B),
    .dsp_OPMODE(dsp_OPMODE),
    .dsp_CEA(dsp_CEA),
    .dsp_CEB(dsp_CEB),
    .dsp_CEM(dsp_CEM),
    .dsp_CEP(dsp_CEP),
    .dsp_CEOPMODE(dsp_CEOPMODE),
    .dsp_RSTP(dsp_RSTP),
    .dsp_P(dsp_P),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Slice model: A1/B1, M and P registers; P starts with junk on purpose
  logic [17:0] a_r = 18'd0;
  logic [17:0] b_r = 18'd0;
  logic [35:0] m_r = 36'd0;
  logic [47:0] p_r = 48'h0000_0BAD_F00D;
  always @(posedge CLK) begin
    if (dsp_CEA) a_r <= dsp_A;
    if (dsp_CEB) b_r <= dsp_B;
    if (dsp_CEM) m_r <= a_r * b_r;
    if (dsp_RSTP) p_r <= 48'd0;
    else if (dsp_CEP && dsp_OPMODE == 8'h09) p_r <= p_r + {12'd0, m_r};
  end
  assign dsp_P = p_r;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int cep_tot = 0;
  int ce_tot = 0;
  always @(negedge CLK) begin
    cep_tot <= cep_tot + int'(dsp_CEP);
    ce_tot  <= ce_tot + int'(dsp_CEA | dsp_CEB | dsp_CEM |
                             dsp_CEP | dsp_RSTP);
  end

  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic issue(input logic [7:0] l);
    @(posedge CLK); #1;
    start = 1'b1;
    len = l;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b,
                      input int gap, output int acc);
    int n;
    n = 0;
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    @(negedge CLK);
    while (!op_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!op_ready) chk("send_timeout", 48'(op_ready), 48'd1);
    acc = cyc;
    @(posedge CLK); #1;
    op_valid = 1'b0;
    repeat (gap) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_res(output int rc);
    int n;
    n = 0;
    @(negedge CLK);
    while (!res_valid && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (!res_valid) chk("res_timeout", 48'(res_valid), 48'd1);
    rc = cyc;
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tx, rc, base;
    logic seen;

    // Busy inputs during reset must not leak to outputs
    op_a = 18'h155;
    op_b = 18'h2AA;
    op_valid = 1'b1;
    start = 1'b1;
    len = 8'd3;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ctl", 48'({op_ready, res_valid, busy, dsp_CEA, dsp_CEB,
                        dsp_CEM, dsp_CEP, dsp_CEOPMODE, dsp_RSTP}), 48'd0);
    chk("rst_ab", 48'({dsp_A, dsp_B}), 48'd0);
    chk("rst_opmode", 48'(dsp_OPMODE), 48'd0);
    chk("rst_res", res_data, 48'd0);
    RST_N = 1'b1;
    start = 1'b0;
    op_valid = 1'b0;
    len = 8'd0;
    @(negedge CLK);
    chk("opmode", 48'({dsp_CEOPMODE, dsp_OPMODE}), 48'h109);
    chk("idle_out", 48'({op_ready, busy, res_valid}), 48'd0);

    // len=3 back-to-back: 6+20+42=68, result at t+6
    issue(8'd3);
    base = cep_tot;
    @(negedge CLK);
    chk("clear_rstp", 48'({dsp_RSTP, busy, op_ready}), 48'b110);
    send(18'd2, 18'd3, 0, t0);
    send(18'd4, 18'd5, 0, tx);
    send(18'd6, 18'd7, 0, tx);
    wait_res(rc);
    chk("b2b_lat", 48'(rc), 48'(t0 + 6));
    chk("b2b_sum", res_data, 48'd68);
    take_res();
    chk("b2b_cep", 48'(cep_tot - base), 48'd3);
    @(negedge CLK);
    chk("b2b_idle", 48'({busy, res_valid}), 48'd0);

    // Same pairs with two idle cycles between them
    issue(8'd3);
    base = cep_tot;
    send(18'd2, 18'd3, 2, tx);
    send(18'd4, 18'd5, 2, tx);
    send(18'd6, 18'd7, 0, tx);
    wait_res(rc);
    chk("gap_sum", res_data, 48'd68);
    take_res();
    chk("gap_cep", 48'(cep_tot - base), 48'd3);

    // len=0: immediate zero result, no slice activity
    base = ce_tot;
    issue(8'd0);
    @(negedge CLK);
    chk("len0_valid", 48'(res_valid), 48'd1);
    chk("len0_data", res_data, 48'd0);
    take_res();
    chk("len0_noce", 48'(ce_tot - base), 48'd0);

    // len=255 with max operands, then back-pressure for 10 cycles
    issue(8'd255);
    send(18'h3FFFF, 18'h3FFFF, 0, t0);
    for (int i = 1; i < 255; i++) send(18'h3FFFF, 18'h3FFFF, 0, tx);
    wait_res(rc);
    chk("max_lat", 48'(rc), 48'(t0 + 258));
    chk("max_sum", res_data, 48'd17523332874495);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      start = (i < 5);
      len = 8'd1;
      @(negedge CLK);
      chk("hold_valid", 48'(res_valid), 48'd1);
      chk("hold_data", res_data, 48'd17523332874495);
    end
    start = 1'b0;
    take_res();
    @(negedge CLK);
    chk("hold_idle", 48'(busy), 48'd0);

    // Reset mid-stream after 2 of 5 pairs, then fresh 3*3 command
    issue(8'd5);
    send(18'd10, 18'd10, 0, tx);
    send(18'd20, 18'd20, 0, tx);
    RST_N = 1'b0;
    #2;
    chk("arst_out", 48'({busy, op_ready, dsp_CEM, dsp_CEP, dsp_RSTP,
                         res_valid}), 48'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    issue(8'd1);
    @(negedge CLK);
    chk("arst_clear", 48'(dsp_RSTP), 48'd1);
    send(18'd3, 18'd3, 0, tx);
    wait_res(rc);
    chk("arst_sum", res_data, 48'd9);
    take_res();

`ifdef MAC_SEQ_ABORT_EN
    // Abort on the second DRAIN cycle, where CEP would otherwise fire
    issue(8'd1);
    send(18'd5, 18'd5, 0, tx);
    @(posedge CLK); #1;
    abort = 1'b1;
    @(negedge CLK);
    chk("abort_ce", 48'({dsp_CEA, dsp_CEM, dsp_CEP}), 48'd0);
    @(posedge CLK); #1;
    abort = 1'b0;
    @(negedge CLK);
    chk("abort_idle", 48'(busy), 48'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      seen = seen | res_valid;
    end
    chk("abort_nores", 48'(seen), 48'd0);
`else
    seen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      seen = seen | res_valid | busy;
    end
    chk("final_idle", 48'(seen), 48'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
